// File: rtl/uart_tx_flex.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_flex
//  Description : UART transmitter for a valid/ready word stream. Frame format
//                is START, DW data bits LSB first, optional parity, then one
//                or two STOP bits. Baud divisor, parity mode and stop-bit
//                count are sampled at each accepted word and held for that
//                frame. Supports CTS gating of frame starts, break
//                generation and back-to-back frames with no idle gap.
//
//  Ports       : clk, rst         clock, asynchronous active-high reset
//                cfg_div          bit period minus one, in clk cycles
//                cfg_par          00 none, 01 odd, 10 even, 11 mark
//                cfg_stop         0 = one stop bit, 1 = two stop bits
//                str_tvalid/tdata/tready   input word stream
//                cts_n            clear-to-send, active-low, asynchronous
//                brk              break request (line held low between frames)
//                busy             frame or break in progress
//                uart_txd         serial output, idle high, from a flop
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_flex #(
   parameter int DW     = 8,
   parameter int DIV_W  = 16,
   parameter bit CTS_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [1:0]       cfg_par,
   input  logic             cfg_stop,
   input  logic             str_tvalid,
   input  logic [DW-1:0]    str_tdata,
   output logic             str_tready,
   input  logic             cts_n,
   input  logic             brk,
   output logic             busy,
   output logic             uart_txd
);

   localparam int             BCW       = $clog2(DW + 4);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DW - 1);
   localparam logic [1:0]     PAR_NONE  = 2'b00;
   localparam logic [1:0]     PAR_ODD   = 2'b01;
   localparam logic [1:0]     PAR_EVEN  = 2'b10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]    shift_q, shift_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       par_q, par_d;
   logic             stop_q, stop_d;
   logic             par_bit_q, par_bit_d;
   logic             txd_q, txd_d;

   logic             cts_ok;
   logic             bit_end;
   logic             last_stop;
   logic             xfer;

   // ------------------------------------------------------------------------
   // Clear-to-send. The synchroniser resets to "not clear" so no frame can
   // start until a real, synchronised CTS has been seen after reset. With CTS
   // ignored, a one-flop enable still keeps str_tready low while in reset.
   // ------------------------------------------------------------------------
   generate
      if (CTS_EN) begin : g_cts_sync
         logic cts_meta_q;
         logic cts_sync_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cts_meta_q <= 1'b1;
               cts_sync_q <= 1'b1;
            end else begin
               cts_meta_q <= cts_n;
               cts_sync_q <= cts_meta_q;
            end
         end

         assign cts_ok = ~cts_sync_q;
      end else begin : g_cts_off
         logic run_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               run_q <= 1'b0;
            end else begin
               run_q <= 1'b1;
            end
         end

         assign cts_ok = run_q;
      end
   endgenerate

   // Bit period ends when the counter reaches the divisor latched for this
   // frame, so a runtime change of cfg_div can never cause an overrun.
   assign bit_end   = (baud_cnt_q == div_q);
   // Stop bits are counted 0 (first) and 1 (second); the final one is the
   // index equal to the latched stop setting.
   assign last_stop = (state_q == STOP) && bit_end &&
                      (bit_cnt_q == {{(BCW-1){1'b0}}, stop_q});

   assign str_tready = cts_ok & ~brk & ((state_q == IDLE) | last_stop);
   assign xfer       = str_tvalid & str_tready;

   assign busy     = (state_q != IDLE);
   assign uart_txd = txd_q;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      div_d      = div_q;
      par_d      = par_q;
      stop_d     = stop_q;
      par_bit_d  = par_bit_q;

      case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (brk) begin
               state_d = BREAK;
            end
         end

         START: begin
            if (bit_end) begin
               state_d    = DATA;
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = (par_q != PAR_NONE) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  shift_d   = {1'b0, shift_q[DW-1:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end

         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end

         STOP: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (last_stop) begin
                  bit_cnt_d = '0;
                  state_d   = brk ? BREAK : IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end else begin
               baud_cnt_d = baud_cnt_q + DIV_W'(1);
            end
         end

         BREAK: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (!brk) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase

      // An accepted word only happens in IDLE or in the last stop-bit cycle;
      // it overrides whatever the case above chose so the next start bit
      // follows immediately. Everything the frame depends on is captured here.
      if (xfer) begin
         state_d    = START;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
         shift_d    = str_tdata;
         div_d      = cfg_div;
         par_d      = cfg_par;
         stop_d     = cfg_stop;
         case (cfg_par)
            PAR_ODD:  par_bit_d = ~^str_tdata;
            PAR_EVEN: par_bit_d = ^str_tdata;
            default:  par_bit_d = 1'b1;
         endcase
      end

      // Line level is computed from the next state so the registered output
      // always lines up with the state register.
      case (state_d)
         IDLE:    txd_d = 1'b1;
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_bit_d;
         STOP:    txd_d = 1'b1;
         BREAK:   txd_d = 1'b0;
         default: txd_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         div_q      <= '0;
         par_q      <= PAR_NONE;
         stop_q     <= 1'b0;
         par_bit_q  <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         par_q      <= par_d;
         stop_q     <= stop_d;
         par_bit_q  <= par_bit_d;
         txd_q      <= txd_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_flex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_flex
//  Description : Directed self-checking bench for uart_tx_flex (DW=8).
//                Checks reset state, frame waveforms for several data and
//                parity/stop settings, zero-gap streaming, CTS gating, break
//                and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_flex;

   logic        clk;
   logic        rst;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_par;
   logic        cfg_stop;
   logic        str_tvalid;
   logic [7:0]  str_tdata;
   logic        str_tready;
   logic        cts_n;
   logic        brk;
   logic        busy;
   logic        uart_txd;

   int n_chk = 0;
   int n_err = 0;

   uart_tx_flex #(
      .DW    (8),
      .DIV_W (16),
      .CTS_EN(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_div   (cfg_div),
      .cfg_par   (cfg_par),
      .cfg_stop  (cfg_stop),
      .str_tvalid(str_tvalid),
      .str_tdata (str_tdata),
      .str_tready(str_tready),
      .cts_n     (cts_n),
      .brk       (brk),
      .busy      (busy),
      .uart_txd  (uart_txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int budget);
      int n;
      n = 0;
      while (!str_tready && n < budget) begin
         tick();
         n++;
      end
      if (!str_tready) check("tready_wait_timeout", 32'd0, 32'd1);
   endtask

   // Presents a word, waits for acceptance and returns just after the edge
   // that took it (frame cycle 0). The config inputs are then scrambled so
   // any failure to hold the latched settings shows up in the waveform.
   task automatic start_frame(input logic [7:0] data, input int div,
                              input logic [1:0] par, input logic stp);
      cfg_div    = 16'(div);
      cfg_par    = par;
      cfg_stop   = stp;
      str_tdata  = data;
      str_tvalid = 1'b1;
      wait_ready(20);
      tick();
      str_tvalid = 1'b0;
      cfg_div    = 16'd7;
      cfg_par    = ~par;
      cfg_stop   = ~stp;
      str_tdata  = ~data;
   endtask

   // Checks txd/busy/tready every cycle from frame cycle 0. pbit is the
   // hand-computed parity bit; rdy_end is tready expected in the final cycle.
   // limit > 0 stops early after that many cycles.
   task automatic check_frame(input logic [7:0] data, input int div,
                              input logic [1:0] par, input logic stp,
                              input logic pbit, input logic rdy_end,
                              input int limit);
      int   nb;
      int   full;
      int   n;
      int   b;
      logic e;
      nb   = 1 + 8 + ((par != 2'b00) ? 1 : 0) + 1 + (stp ? 1 : 0);
      full = nb * (div + 1);
      n    = (limit > 0 && limit < full) ? limit : full;
      for (int c = 0; c < n; c++) begin
         b = c / (div + 1);
         if (b == 0)                       e = 1'b0;
         else if (b <= 8)                  e = data[b-1];
         else if (par != 2'b00 && b == 9)  e = pbit;
         else                              e = 1'b1;
         check($sformatf("txd[%0d]", c), 32'(uart_txd), 32'(e));
         check($sformatf("busy[%0d]", c), 32'(busy), 32'd1);
         check($sformatf("tready[%0d]", c), 32'(str_tready),
               (c == full - 1) ? 32'(rdy_end) : 32'd0);
         tick();
      end
   endtask

   task automatic run_frame(input logic [7:0] data, input int div,
                            input logic [1:0] par, input logic stp, input logic pbit);
      start_frame(data, div, par, stp);
      check_frame(data, div, par, stp, pbit, 1'b1, 0);
      check("post_txd", 32'(uart_txd), 32'd1);
      check("post_busy", 32'(busy), 32'd0);
      check("post_tready", 32'(str_tready), 32'd1);
   endtask

   logic [7:0] words [3];
   logic       expb  [30];
   int         xfers;
   logic       hs;

   initial begin
      rst        = 1'b1;
      cts_n      = 1'b0;
      brk        = 1'b0;
      str_tvalid = 1'b0;
      str_tdata  = 8'h00;
      cfg_div    = 16'd3;
      cfg_par    = 2'b00;
      cfg_stop   = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_txd", 32'(uart_txd), 32'd1);
      check("rst_tready", 32'(str_tready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();
      check("cts_sync1_tready", 32'(str_tready), 32'd0);
      tick();
      check("cts_sync2_tready", 32'(str_tready), 32'd1);

      // ---------------- basic frame 0x55, 4 clk/bit ----------------
      run_frame(8'h55, 3, 2'b00, 1'b0, 1'b0);

      // ---------------- parity modes on 0x07, two stop bits ----------------
      run_frame(8'h07, 3, 2'b01, 1'b1, 1'b0);   // odd: three ones -> 0
      run_frame(8'h07, 3, 2'b10, 1'b1, 1'b1);   // even -> 1
      run_frame(8'h07, 3, 2'b11, 1'b1, 1'b1);   // mark -> 1

      // ---------------- back-to-back, div=0 ----------------
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'hFF;
      for (int w = 0; w < 3; w++) begin
         expb[w*10] = 1'b0;
         for (int k = 0; k < 8; k++) expb[w*10 + 1 + k] = words[w][k];
         expb[w*10 + 9] = 1'b1;
      end
      cfg_div    = 16'd0;
      cfg_par    = 2'b00;
      cfg_stop   = 1'b0;
      str_tdata  = words[0];
      str_tvalid = 1'b1;
      xfers      = 0;
      wait_ready(20);
      for (int c = 0; c < 31; c++) begin
         if (c > 0) begin
            check($sformatf("b2b_txd[%0d]", c - 1), 32'(uart_txd), 32'(expb[c-1]));
            check($sformatf("b2b_busy[%0d]", c - 1), 32'(busy), 32'd1);
         end
         hs = str_tvalid & str_tready;
         tick();
         if (hs) begin
            xfers++;
            if (xfers < 3) str_tdata = words[xfers];
            else           str_tvalid = 1'b0;
         end
      end
      check("b2b_xfers", 32'(xfers), 32'd3);
      check("b2b_end_txd", 32'(uart_txd), 32'd1);
      check("b2b_end_busy", 32'(busy), 32'd0);

      // ---------------- CTS gating ----------------
      cfg_div  = 16'd1;
      cfg_par  = 2'b00;
      cfg_stop = 1'b0;
      cts_n    = 1'b1;
      tick();
      tick();
      tick();
      str_tdata  = 8'h3C;
      str_tvalid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check("cts_hold_tready", 32'(str_tready), 32'd0);
         check("cts_hold_txd", 32'(uart_txd), 32'd1);
         check("cts_hold_busy", 32'(busy), 32'd0);
         tick();
      end
      cts_n = 1'b0;
      tick();
      check("cts_rise1_tready", 32'(str_tready), 32'd0);
      tick();
      check("cts_rise2_tready", 32'(str_tready), 32'd1);
      tick();
      str_tvalid = 1'b0;
      cts_n      = 1'b1;                       // mid-frame: must not stop it
      check_frame(8'h3C, 1, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      check("cts_end_txd", 32'(uart_txd), 32'd1);
      check("cts_end_busy", 32'(busy), 32'd0);
      check("cts_end_tready", 32'(str_tready), 32'd0);
      cts_n = 1'b0;
      tick();
      tick();
      check("cts_back_tready", 32'(str_tready), 32'd1);

      // ---------------- break in IDLE ----------------
      brk = 1'b1;
      #1;
      check("brk_idle_tready", 32'(str_tready), 32'd0);
      tick();
      check("brk_idle_txd", 32'(uart_txd), 32'd0);
      check("brk_idle_busy", 32'(busy), 32'd1);
      brk = 1'b0;
      tick();
      check("brk_idle_rel_txd", 32'(uart_txd), 32'd1);
      check("brk_idle_rel_busy", 32'(busy), 32'd0);

      // ---------------- break requested mid-frame ----------------
      start_frame(8'h55, 1, 2'b00, 1'b0);
      brk = 1'b1;
      check_frame(8'h55, 1, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      for (int c = 0; c < 4; c++) begin
         check("brk_txd", 32'(uart_txd), 32'd0);
         check("brk_tready", 32'(str_tready), 32'd0);
         check("brk_busy", 32'(busy), 32'd1);
         tick();
      end
      brk = 1'b0;
      tick();
      check("brk_rel_txd", 32'(uart_txd), 32'd1);
      check("brk_rel_busy", 32'(busy), 32'd0);
      check("brk_rel_tready", 32'(str_tready), 32'd1);

      // ---------------- reset during data bit 4 ----------------
      start_frame(8'hA5, 3, 2'b00, 1'b0);
      check_frame(8'hA5, 3, 2'b00, 1'b0, 1'b0, 1'b0, 21);
      rst = 1'b1;
      #1;
      check("midrst_txd", 32'(uart_txd), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_tready", 32'(str_tready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("postrst_sync1_tready", 32'(str_tready), 32'd0);
      tick();
      check("postrst_sync2_tready", 32'(str_tready), 32'd1);
      run_frame(8'h3C, 2, 2'b10, 1'b0, 1'b0);  // even, four ones -> 0

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_flex.md
Name: uart_tx_flex

Overview:
Parametrised UART transmitter that serialises an AXI-Stream-style byte/word stream onto a single TXD line.
- Data width is set by parameter; baud divisor, parity mode and stop-bit count are selectable at runtime.
- Adds CTS flow control, break generation, a busy flag and zero-gap back-to-back frames.
- Sits between a TX FIFO / command source and the pad.

Parameters:
DW, 8, data bits per frame, legal 5..9, sent LSB first
DIV_W, 16, width of runtime baud divisor
CTS_EN, 1, 1 = honour cts_n; 0 = ignore cts_n (treated as always asserted)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cfg_div  input  DIV_W  bit period minus one, in clk cycles (bit period = cfg_div+1; 0 is legal, giving 1 clk/bit)
cfg_par  input  2  00 none, 01 odd, 10 even, 11 mark (parity bit always 1)
cfg_stop  input  1  0 = one stop bit, 1 = two stop bits
str_tvalid  input  1  stream data valid
str_tdata  input  DW  stream data
str_tready  output  1  stream ready
cts_n  input  1  clear-to-send, active-low, asynchronous (2-FF synchronised internally)
brk  input  1  break request: hold TXD low while asserted, once the line is between frames
busy  output  1  frame or break in progress
uart_txd  output  1  serial output, idle high

Behaviour:
- Reset: uart_txd=1, str_tready=0, busy=0; FSM=IDLE; all counters 0; CTS synchroniser flops reset to 1 (not clear).
- A reset assertion mid-frame aborts the frame; uart_txd returns to 1 asynchronously.
- cts_ok = CTS_EN ? ~cts_sync : 1, where cts_sync is cts_n after two flops.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- str_tready = cts_ok & ~brk & (state==IDLE | last_cycle_of_final_stop_bit).
  - str_tready never depends on str_tvalid.
  - Transfer = str_tvalid & str_tready.
- On transfer, the following are latched and held constant for the whole frame; config changes mid-frame take effect on the next frame:
  - str_tdata into the shift register
  - cfg_div, cfg_par, cfg_stop
  - the parity bit: odd = ~^data, even = ^data, mark = 1
- Transfer cycle N: state becomes START at edge N+1, and uart_txd=0 from cycle N+1.
- Every bit lasts exactly latched cfg_div+1 clk cycles.
  - The baud counter reloads to 0 at each bit start and counts up.
  - Bit end is when count == div.
- Bit order: START(0), DW data bits LSB first, PARITY if cfg_par != 00, then 1 or 2 STOP(1) bits.
- Frame length = (1 + DW + (par!=0) + 1 + stop) * (div+1) cycles.
- End of frame (last cycle of final stop bit):
  - If a transfer occurs that cycle, go directly to START: no idle gap.
  - Else, if brk is asserted, go to BREAK.
  - Else go to IDLE.
- IDLE with brk=1: go to BREAK next cycle.
- BREAK: uart_txd=0, str_tready=0. On brk deassertion, go to IDLE next cycle; uart_txd=1 in that cycle.
  - Minimum break length and stop-after-break time are the user's responsibility.
- brk asserted mid-frame does not corrupt the frame. BREAK begins after the final stop bit.
- cts_n deasserted mid-frame does not stop the frame. Only frame start is gated.
- busy = (state != IDLE).
- uart_txd is registered (glitch-free) and driven directly from a flop.
- Counters:
  - Baud counter is DIV_W bits; no overflow, since the compare is against the latched div.
  - Bit counter is ceil(log2(DW+4)) bits.

Test Plan:
- DW=8, div=3, par=00, stop=0; send 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 at 4 clk/bit (40 cycles); first 0 one cycle after transfer; busy high 40 cycles; tready high again on cycle 40.
- div=3, send 0x07 with par=01 then par=10 then par=11 -> parity bit 0, then 1, then 1; stop=1 gives two high bits (12 frame bits, 48 cycles).
- tvalid held high, 3 words 0xA5,0x3C,0xFF, div=0 -> 30 contiguous bit periods; stop bit followed immediately by next start bit; exactly 3 transfers.
- cts_n=1 with tvalid=1 -> tready=0 and txd=1 indefinitely; drop cts_n -> tready rises 2 cycles later (sync), then the frame starts; raise cts_n mid-frame -> the frame completes.
- Assert brk mid-frame -> the frame completes, then txd=0 and tready=0 while brk=1; release -> txd=1 the next cycle and tready=1 in IDLE.
- Assert rst during DATA bit 4 -> txd=1, busy=0, tready=0 immediately; after release the next frame is transmitted correctly from its start bit.
